// File: rtl/ssa_pkg.sv
// Shared definitions for the SRAM port arbiter: default geometry, arbiter
// state encoding and a small round-robin index helper.
package ssa_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int MAX_REQ    = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Next requester index after i, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector: scans req starting at rr,
// wrapping modulo N, and reports the first set bit.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    // rr is always < N and k < N, so one conditional subtract is enough.
    function automatic logic [IW-1:0] slot(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // First requester at or after the pointer wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[slot(rr, k)]) begin
                found               = 1'b1;
                idx                 = slot(rr, k);
                onehot[slot(rr, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit SRAM among N_REQ
// requesters, with lockable ownership for bursts and a watchdog that breaks
// locks held too long. All state moves on negedge; the SRAM samples on posedge.
module ram_port_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ADDR_WIDTH = ssa_pkg::ADDR_WIDTH,
    parameter int LOCK_MAX   = 1023
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ-1:0]                 req_lock,
    input  logic [N_REQ-1:0][3:0]            req_we,
    input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ-1:0][31:0]           req_wdata,
    output logic [N_REQ-1:0]                 gnt,
    output logic [N_REQ-1:0]                 rvalid,
    output logic [31:0]                      rdata,
    output logic                             RAM_EN,
    output logic [3:0]                       RAM_WE,
    output logic [ADDR_WIDTH-1:0]            RAM_A,
    output logic [31:0]                      RAM_Di,
    input  logic [31:0]                      RAM_Do,
    output logic                             lock_err
);
    import ssa_pkg::*;

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WDW = $clog2(LOCK_MAX + 1);

    arb_state_e       state;
    logic [IW-1:0]    owner, rr, pick_ptr, pick_idx, tag_idx;
    logic [N_REQ-1:0] elig, pick_oh;
    logic             pick_found, grant, wd_fire, tag_vld;
    logic [WDW-1:0]   wd_cnt;

    // While owned, only the owner is eligible and the scan starts at it.
    always_comb begin
        elig     = (state == OWNED) ? (req & (N_REQ'(1) << owner)) : req;
        pick_ptr = (state == OWNED) ? owner : rr;
        wd_fire  = (state == OWNED) && (wd_cnt == WDW'(LOCK_MAX - 1));
        grant    = pick_found && !wd_fire;
    end

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req    (elig),
        .rr     (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    // Grant pulse and SRAM pin registers; address/data hold when idle.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            RAM_EN <= 1'b0;
            RAM_WE <= 4'h0;
            RAM_A  <= '0;
            RAM_Di <= '0;
        end else begin
            gnt    <= grant ? pick_oh : '0;
            RAM_EN <= grant;
            RAM_WE <= grant ? req_we[pick_idx] : 4'h0;
            if (grant) begin
                RAM_A  <= req_addr[pick_idx];
                RAM_Di <= req_wdata[pick_idx];
            end
        end
    end

    // One-deep read tag: the SRAM answer lands one negedge after the grant.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= 1'b0;
            tag_idx <= '0;
            rvalid  <= '0;
            rdata   <= '0;
        end else begin
            tag_vld <= grant && (req_we[pick_idx] == 4'h0);
            tag_idx <= pick_idx;
            rvalid  <= tag_vld ? (N_REQ'(1) << tag_idx) : '0;
            if (tag_vld) rdata <= RAM_Do;
        end
    end

    // Ownership FSM, round-robin pointer and lock watchdog.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= '0;
            rr       <= '0;
            wd_cnt   <= '0;
            lock_err <= 1'b0;
        end else if (wd_fire) begin
            state    <= IDLE;
            rr       <= IW'(wrap_inc(32'(owner), N_REQ));
            lock_err <= 1'b1;
        end else if (state == IDLE) begin
            if (grant) begin
                if (req_lock[pick_idx]) begin
                    state  <= OWNED;
                    owner  <= pick_idx;
                    wd_cnt <= '0;
                end else begin
                    rr <= IW'(wrap_inc(32'(pick_idx), N_REQ));
                end
            end
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (grant && !req_lock[owner]) begin
                state <= IDLE;
                rr    <= IW'(wrap_inc(32'(owner), N_REQ));
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench: a behavioural arbiter model pushes one expected record per
// negedge; a monitor pops and compares at posedge. A simple SRAM model sits
// on the RAM pins; a shadow copy of memory predicts read data.
module tb_ram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 9;
    localparam int LM = 8;
    localparam int M_OFF = 0, M_ALLRD = 1, M_WR = 2, M_HOG = 3, M_RAND = 4, M_STREAM = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic [N-1:0] req, req_lock, gnt, rvalid;
    logic [N-1:0][3:0] req_we;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0][31:0] req_wdata;
    logic [31:0] rdata, RAM_Di, RAM_Do;
    logic RAM_EN, lock_err;
    logic [3:0] RAM_WE;
    logic [AW-1:0] RAM_A;

    always #5 clk = ~clk;

    ram_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid),
        .rdata(rdata), .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A),
        .RAM_Di(RAM_Di), .RAM_Do(RAM_Do), .lock_err(lock_err)
    );

    int tests = 0, fails = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    // SRAM macro model: acts on posedge.
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        RAM_Do = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (RAM_EN) begin
                if (RAM_WE == 4'h0) RAM_Do = mem[RAM_A];
                else for (int b = 0; b < 4; b++)
                    if (RAM_WE[b]) mem[RAM_A][8*b +: 8] = RAM_Di[8*b +: 8];
            end
        end
    end

    typedef struct packed {
        logic [N-1:0] gnt; logic en; logic [3:0] we; logic [AW-1:0] a;
        logic [31:0] di; logic rd; logic [31:0] rdat; logic lerr;
    } rec_t;
    rec_t q[$];
    bit model_on = 0;

    // Reference model of the arbitration rules, one decision per negedge.
    logic [31:0] shadow [0:(1<<AW)-1];
    bit m_owned, m_lerr;
    int m_owner, m_rr, m_wd;
    logic [AW-1:0] m_a;
    logic [31:0] m_di;
    initial begin
        int w;
        rec_t r;
        for (int i = 0; i < (1<<AW); i++) shadow[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_owned = 0; m_lerr = 0; m_owner = 0; m_rr = 0; m_wd = 0; m_a = '0; m_di = '0;
            end else if (model_on) begin
                w = -1;
                if (m_owned) begin
                    m_wd++;
                    if (m_wd >= LM) begin
                        m_owned = 0; m_rr = (m_owner + 1) % N; m_lerr = 1;
                    end else if (req[m_owner]) begin
                        w = m_owner;
                        if (!req_lock[w]) begin m_owned = 0; m_rr = (w + 1) % N; end
                    end
                end else begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
                    if (w >= 0) begin
                        if (req_lock[w]) begin m_owned = 1; m_owner = w; m_wd = 0; end
                        else m_rr = (w + 1) % N;
                    end
                end
                r = '0;
                if (w >= 0) begin
                    r.gnt[w] = 1'b1; r.en = 1'b1; r.we = req_we[w];
                    m_a = req_addr[w]; m_di = req_wdata[w];
                    if (r.we == 4'h0) begin r.rd = 1'b1; r.rdat = shadow[m_a]; end
                    else for (int b = 0; b < 4; b++)
                        if (r.we[b]) shadow[m_a][8*b +: 8] = m_di[8*b +: 8];
                end
                r.a = m_a; r.di = m_di; r.lerr = m_lerr;
                q.push_back(r);
            end
        end
    end

    // Monitor: compare DUT outputs with the model's record for this cycle.
    int g2_cnt = 0, r2_cnt = 0;
    initial begin
        logic [N-1:0] exp_rv;
        logic [31:0] exp_rd;
        rec_t r;
        exp_rv = '0; exp_rd = '0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete(); exp_rv = '0;
            end else begin
                if (gnt[2]) g2_cnt++;
                if (rvalid[2]) r2_cnt++;
                if (q.size() > 0) begin
                    r = q.pop_front();
                    chk("rvalid", rvalid, exp_rv);
                    if (exp_rv != '0) chk("rdata", rdata, exp_rd);
                    chk("gnt", gnt, r.gnt);
                    chk("ram_en", RAM_EN, r.en);
                    chk("ram_we", RAM_WE, r.we);
                    chk("ram_a", RAM_A, r.a);
                    chk("ram_di", RAM_Di, r.di);
                    chk("lock_err", lock_err, r.lerr);
                    exp_rv = r.rd ? r.gnt : '0;
                    exp_rd = r.rdat;
                end
            end
        end
    end

    // Requester behaviour (driven only from the main process).
    int mode = M_OFF, stream_n = 0, wr_step = 0;
    bit hog_sent = 0;
    bit busy [N];
    int burst [N];

    task automatic drive_step();
        bit nw, lk;
        logic [3:0] we;
        logic [AW-1:0] ad;
        logic [31:0] wd;
        for (int i = 0; i < N; i++) if (gnt[i]) busy[i] = 0;
        for (int i = 0; i < N; i++) begin
            if (!busy[i]) begin
                nw = 0; lk = 0; we = 4'h0; ad = AW'($urandom % (1<<AW)); wd = $urandom;
                case (mode)
                    M_ALLRD: nw = 1;
                    M_WR: if (i == 1 && wr_step < 2) begin
                        nw = 1; ad = AW'(5); wd = 32'hDEADBEEF;
                        we = (wr_step == 0) ? 4'hF : 4'h0; wr_step++;
                    end
                    M_HOG: if (i == 0 && !hog_sent) begin nw = 1; lk = 1; hog_sent = 1; end
                           else if (i == 1) nw = 1;
                    M_STREAM: if (i == 2 && stream_n < 512) begin
                        nw = 1; ad = AW'(stream_n); stream_n++;
                    end
                    M_RAND: begin
                        if (burst[i] > 0) begin
                            if ($urandom % 4 != 0) nw = 1;
                        end else if ($urandom % 3 == 0) begin
                            nw = 1;
                            burst[i] = ($urandom % 4 == 0) ? 2 + int'($urandom % 10) : 1;
                        end
                        if (nw) begin
                            lk = (burst[i] > 1); burst[i]--;
                            we = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                            ad = AW'($urandom % 32);
                        end
                    end
                    default: nw = 0;
                endcase
                busy[i] = nw; req[i] = nw; req_lock[i] = lk;
                req_we[i] = we; req_addr[i] = ad; req_wdata[i] = wd;
            end
        end
    endtask

    task automatic run(input int md, input int cycles);
        mode = md;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            drive_step();
        end
    endtask

    initial begin
        int g0, r0;
        req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < N; i++) begin busy[i] = 0; burst[i] = 0; end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);       chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);   chk("rst_ram_en", RAM_EN, 0);
        chk("rst_ram_we", RAM_WE, 0); chk("rst_ram_a", RAM_A, 0);
        chk("rst_ram_di", RAM_Di, 0); chk("rst_lock_err", lock_err, 0);
        rst_n = 1'b1;
        model_on = 1;

        run(M_ALLRD, 12);  run(M_OFF, 6);
        run(M_WR, 6);      run(M_OFF, 4);
        run(M_HOG, 20);
        chk("hog_lock_err", lock_err, 1);
        run(M_OFF, 20);
        run(M_RAND, 3000); run(M_OFF, 24);
        model_on = 0;

        // Read granted to req1, then reset before its data returns.
        @(posedge clk); #1;
        req = 3'b010; req_lock = '0; req_we[1] = 4'h0; req_addr[1] = AW'(7);
        @(negedge clk); #1;
        chk("mid_gnt", gnt, 3'b010);
        chk("mid_ram_en", RAM_EN, 1);
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0;
        #1;
        chk("mid_rst_gnt", gnt, 0);     chk("mid_rst_rvalid", rvalid, 0);
        chk("mid_rst_rdata", rdata, 0); chk("mid_rst_ram_en", RAM_EN, 0);
        chk("mid_rst_ram_a", RAM_A, 0); chk("mid_rst_lock_err", lock_err, 0);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid_no_rvalid", rvalid, 0);
        @(negedge clk); #1;
        chk("mid_no_rvalid2", rvalid, 0);

        // Full reset, then requester 2 streams 512 reads.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) busy[i] = 0;
        model_on = 1;
        g0 = g2_cnt; r0 = r2_cnt;
        run(M_STREAM, 560); run(M_OFF, 6);
        chk("stream_gnt_count", g2_cnt - g0, 512);
        chk("stream_rvalid_count", r2_cnt - r0, 512);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
